// File: rtl/player_defs.sv
`default_nettype none
// ============================================================================
// Package     : player_defs
// Description : Shared widths, player FSM state encoding and small arithmetic
//               helpers for the player damage stage and the render-side
//               collider.
// Revision    : 1.0 - initial release
// ============================================================================
package player_defs;

   localparam int COORD_W     = 10;   // screen coordinate / size width
   localparam int COORD_EXT_W = 11;   // coordinate sums, wide enough not to wrap
   localparam int HP_W        = 8;
   localparam int DMG_W       = 4;

   typedef enum logic [1:0] {
      ST_ALIVE      = 2'd0,
      ST_INVINCIBLE = 2'd1,
      ST_DEAD       = 2'd2
   } player_state_t;

   // HP subtraction that floors at zero instead of wrapping.
   function automatic logic [HP_W-1:0] hp_sat_sub(input logic [HP_W-1:0] hp,
                                                   input logic [HP_W-1:0] loss);
      return (hp > loss) ? (hp - loss) : '0;
   endfunction

   function automatic logic [DMG_W-1:0] dmg_max(input logic [DMG_W-1:0] a,
                                                 input logic [DMG_W-1:0] b);
      return (a > b) ? a : b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/player_damage_controller_rect_overlap_check.sv
`default_nettype none
// ============================================================================
// Module      : rect_overlap_check
// Description : Combinational AABB overlap test. Rectangle A (the player) is
//               shrunk by MARGIN px on every side before testing against B.
//               An A that is no larger than 2*MARGIN on either axis never hits.
// Ports       : i_a_x/i_a_y/i_a_w/i_a_h  rectangle A top-left and size
//               i_b_x/i_b_y/i_b_w/i_b_h  rectangle B top-left and size
//               o_overlap                 1 when shrunk A overlaps B
// Revision    : 1.0 - initial release
// ============================================================================
module rect_overlap_check
   import player_defs::*;
#(
   parameter int MARGIN = 4
) (
   input  logic [COORD_W-1:0] i_a_x,
   input  logic [COORD_W-1:0] i_a_y,
   input  logic [COORD_W-1:0] i_a_w,
   input  logic [COORD_W-1:0] i_a_h,
   input  logic [COORD_W-1:0] i_b_x,
   input  logic [COORD_W-1:0] i_b_y,
   input  logic [COORD_W-1:0] i_b_w,
   input  logic [COORD_W-1:0] i_b_h,
   output logic               o_overlap
);

   localparam logic [COORD_EXT_W-1:0] c_margin    = COORD_EXT_W'(MARGIN);
   localparam logic [COORD_EXT_W-1:0] c_min_extent = COORD_EXT_W'(2 * MARGIN);

   logic [COORD_EXT_W-1:0] w_ax0, w_ax1, w_ay0, w_ay1;
   logic [COORD_EXT_W-1:0] w_bx1, w_by1;
   logic                   w_a_too_small;

   // All sums are 11 bits so 1023 + 1023 cannot wrap.
   assign w_ax0 = {1'b0, i_a_x} + c_margin;
   assign w_ay0 = {1'b0, i_a_y} + c_margin;
   // Only meaningful when the extent exceeds 2*MARGIN; gated below otherwise.
   assign w_ax1 = {1'b0, i_a_x} + {1'b0, i_a_w} - c_margin;
   assign w_ay1 = {1'b0, i_a_y} + {1'b0, i_a_h} - c_margin;
   assign w_bx1 = {1'b0, i_b_x} + {1'b0, i_b_w};
   assign w_by1 = {1'b0, i_b_y} + {1'b0, i_b_h};

   assign w_a_too_small = ({1'b0, i_a_w} <= c_min_extent) || ({1'b0, i_a_h} <= c_min_extent);

   assign o_overlap = !w_a_too_small
                   && (w_ax0 < w_bx1) && ({1'b0, i_b_x} < w_ax1)
                   && (w_ay0 < w_by1) && ({1'b0, i_b_y} < w_ay1);

endmodule
`default_nettype wire

// File: rtl/player_damage_controller.sv
`default_nettype none
// ============================================================================
// Module      : player_damage_controller
// Description : Accumulates per-frame hazard overlap against the player box,
//               commits the worst damage of the frame on the last beat and
//               runs the ALIVE / INVINCIBLE / DEAD player state with a blink
//               output for the renderer.
// Config      : PLAYER_KARMA_EN - a committed hit costs 1 HP immediately and
//               the rest is parked in karma_hp, drained 1 HP per
//               KARMA_DRAIN_TICKS ticks, never below 1 HP.
// Ports       : clk_player_control, reset (sync, active-high)
//               player_pos_x/y, player_w/h      live player box
//               obj_valid/x/y/w/h/damage/last   hazard beat stream
//               hp, karma_hp, hit_pulse, invincible, blink_visible,
//               player_dead                     status to HUD/game state
// Revision    : 1.0 - initial release
// ============================================================================
module player_damage_controller
   import player_defs::*;
#(
   parameter int MAX_HP            = 92,
   parameter int HITBOX_MARGIN     = 4,
   parameter int INVINCIBLE_TICKS  = 60,
   parameter int BLINK_PERIOD      = 4,
   parameter int KARMA_DRAIN_TICKS = 30
) (
   input  logic               clk_player_control,
   input  logic               reset,
   input  logic [COORD_W-1:0] player_pos_x,
   input  logic [COORD_W-1:0] player_pos_y,
   input  logic [COORD_W-1:0] player_w,
   input  logic [COORD_W-1:0] player_h,
   input  logic               obj_valid,
   input  logic [COORD_W-1:0] obj_x,
   input  logic [COORD_W-1:0] obj_y,
   input  logic [COORD_W-1:0] obj_w,
   input  logic [COORD_W-1:0] obj_h,
   input  logic [DMG_W-1:0]   obj_damage,
   input  logic               obj_last,
   output logic [HP_W-1:0]    hp,
   output logic [HP_W-1:0]    karma_hp,
   output logic               hit_pulse,
   output logic               invincible,
   output logic               blink_visible,
   output logic               player_dead
);

   localparam int                    c_inv_cnt_w = $clog2(INVINCIBLE_TICKS + 1);
   localparam logic [c_inv_cnt_w-1:0] c_inv_load  = c_inv_cnt_w'(INVINCIBLE_TICKS);
   localparam logic [c_inv_cnt_w-1:0] c_blink_per = c_inv_cnt_w'(BLINK_PERIOD);
   localparam logic [HP_W-1:0]       c_max_hp    = HP_W'(MAX_HP);

   if (MAX_HP < 1 || MAX_HP > 255 || INVINCIBLE_TICKS < 1 || BLINK_PERIOD < 1
       || KARMA_DRAIN_TICKS < 1) begin : g_bad_params
      $error("player_damage_controller: invalid parameter set");
   end

   // ---------------------------------------------------------------- overlap
   logic w_beat_hit;

   rect_overlap_check #(
      .MARGIN (HITBOX_MARGIN)
   ) u_overlap (
      .i_a_x     (player_pos_x),
      .i_a_y     (player_pos_y),
      .i_a_w     (player_w),
      .i_a_h     (player_h),
      .i_b_x     (obj_x),
      .i_b_y     (obj_y),
      .i_b_w     (obj_w),
      .i_b_h     (obj_h),
      .o_overlap (w_beat_hit)
   );

   // ----------------------------------------------------- frame accumulation
   logic             r_frame_hit;
   logic [DMG_W-1:0] r_frame_dmg;
   logic             w_frame_end;
   logic             w_commit_hit;
   logic [DMG_W-1:0] w_commit_dmg;
   logic             w_hit_commit;

   // The last beat is folded in combinationally so it counts in its own commit.
   assign w_frame_end  = obj_valid && obj_last;
   assign w_commit_hit = r_frame_hit || (obj_valid && w_beat_hit);
   assign w_commit_dmg = dmg_max(r_frame_dmg, (obj_valid && w_beat_hit) ? obj_damage : '0);

   always_ff @(posedge clk_player_control) begin
      if (reset || w_frame_end) begin
         r_frame_hit <= 1'b0;
         r_frame_dmg <= '0;
      end else if (obj_valid) begin
         r_frame_hit <= w_commit_hit;
         r_frame_dmg <= w_commit_dmg;
      end
   end

   // ------------------------------------------------------------ player FSM
   player_state_t          r_state, w_state_next;
   logic [HP_W-1:0]        r_hp, w_hp_next;
   logic [c_inv_cnt_w-1:0] r_inv_cnt, w_inv_cnt_next;
   logic                   r_blink, w_blink_next;
   logic                   r_hit_pulse, w_hit_pulse_next;
   logic [HP_W-1:0]        w_hit_loss;

   // Hits only land while ALIVE; a commit on the expiry edge is still ignored.
   assign w_hit_commit = w_frame_end && w_commit_hit && (w_commit_dmg != '0)
                      && (r_state == ST_ALIVE);

`ifdef PLAYER_KARMA_EN
   localparam int                   c_drain_w    = $clog2(KARMA_DRAIN_TICKS + 1);
   localparam logic [c_drain_w-1:0] c_drain_last = c_drain_w'(KARMA_DRAIN_TICKS - 1);

   logic [HP_W-1:0]      r_karma, w_karma_next;
   logic [c_drain_w-1:0] r_drain_cnt, w_drain_cnt_next;
   logic [HP_W:0]        w_karma_sum;
   logic [HP_W-1:0]      w_karma_sat;

   assign w_hit_loss  = HP_W'(1);
   // commit damage is at least 1 here, so the -1 cannot underflow
   assign w_karma_sum = {1'b0, r_karma} + (HP_W+1)'(w_commit_dmg) - (HP_W+1)'(1);
   assign w_karma_sat = w_karma_sum[HP_W] ? '1 : w_karma_sum[HP_W-1:0];
`else
   assign w_hit_loss  = HP_W'(w_commit_dmg);
`endif

   always_ff @(posedge clk_player_control) begin
      if (reset) begin
         r_state     <= ST_ALIVE;
         r_hp        <= c_max_hp;
         r_inv_cnt   <= '0;
         r_blink     <= 1'b1;
         r_hit_pulse <= 1'b0;
`ifdef PLAYER_KARMA_EN
         r_karma     <= '0;
         r_drain_cnt <= '0;
`endif
      end else begin
         r_state     <= w_state_next;
         r_hp        <= w_hp_next;
         r_inv_cnt   <= w_inv_cnt_next;
         r_blink     <= w_blink_next;
         r_hit_pulse <= w_hit_pulse_next;
`ifdef PLAYER_KARMA_EN
         r_karma     <= w_karma_next;
         r_drain_cnt <= w_drain_cnt_next;
`endif
      end
   end

   always_comb begin
      w_state_next     = r_state;
      w_hp_next        = r_hp;
      w_inv_cnt_next   = r_inv_cnt;
      w_blink_next     = r_blink;
      w_hit_pulse_next = 1'b0;
`ifdef PLAYER_KARMA_EN
      w_karma_next     = r_karma;
      w_drain_cnt_next = r_drain_cnt;
`endif
      case (r_state)
         ST_ALIVE: begin
            if (w_hit_commit) begin
               w_hit_pulse_next = 1'b1;
               w_hp_next        = hp_sat_sub(r_hp, w_hit_loss);
`ifdef PLAYER_KARMA_EN
               w_karma_next     = w_karma_sat;
`endif
               // A killing hit goes straight to DEAD, skipping invincibility.
               if (w_hp_next == '0) begin
                  w_state_next = ST_DEAD;
                  w_blink_next = 1'b1;
               end else begin
                  w_state_next   = ST_INVINCIBLE;
                  w_inv_cnt_next = c_inv_load;
               end
            end
         end
         ST_INVINCIBLE: begin
            w_inv_cnt_next = r_inv_cnt - c_inv_cnt_w'(1);
            if ((r_inv_cnt % c_blink_per) == '0) begin
               w_blink_next = !r_blink;
            end
            if (r_inv_cnt == c_inv_cnt_w'(1)) begin
               w_state_next = ST_ALIVE;
               w_blink_next = 1'b1;
            end
         end
         ST_DEAD: begin
            w_blink_next = 1'b1;
         end
         default: begin
            w_state_next = ST_ALIVE;
         end
      endcase
`ifdef PLAYER_KARMA_EN
      // Drain runs in any state while it cannot kill; on a hit edge the
      // counter holds so the drain lands one tick later.
      if ((r_karma != '0) && (r_hp > HP_W'(1))) begin
         if (!w_hit_commit) begin
            if (r_drain_cnt == c_drain_last) begin
               w_hp_next        = r_hp - HP_W'(1);
               w_karma_next     = r_karma - HP_W'(1);
               w_drain_cnt_next = '0;
            end else begin
               w_drain_cnt_next = r_drain_cnt + c_drain_w'(1);
            end
         end
      end else begin
         w_drain_cnt_next = '0;
      end
`endif
   end

   assign hp            = r_hp;
`ifdef PLAYER_KARMA_EN
   assign karma_hp      = r_karma;
`else
   assign karma_hp      = '0;
`endif
   assign hit_pulse     = r_hit_pulse;
   assign invincible    = (r_state == ST_INVINCIBLE);
   assign blink_visible = r_blink;
   assign player_dead   = (r_state == ST_DEAD);

endmodule
`default_nettype wire
